// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin merge of two byte producers into the TX FIFO,
// plus a drain FSM that feeds the UART transmitter with gap and ack timeout.
`timescale 1ns/1ps
module uart_tx_scheduler #(
    parameter int WIDTH       = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in0_valid,
    input  logic [WIDTH-1:0]     in0_data,
    output logic                 in0_ready,
    input  logic                 in1_valid,
    input  logic [WIDTH-1:0]     in1_data,
    output logic                 in1_ready,
    output logic                 fifo_wr_en,
    output logic [WIDTH-1:0]     fifo_din,
    input  logic                 fifo_full,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic                 tx_start,
    output logic [WIDTH-1:0]     tx_data,
    input  logic                 tx_busy,
    output logic [CNT_WIDTH-1:0] sent_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 timeout_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_WAIT_ACK,
        S_BUSY,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic                 rr_q, rr_d;
    logic                 grant1;
    logic [WIDTH-1:0]     tx_data_q, tx_data_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 err_q, err_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;

    // Arbiter: one FIFO write per cycle, ties broken by the rr pointer
    always_comb begin
        grant1     = in1_valid & (~in0_valid | rr_q);
        fifo_wr_en = (in0_valid | in1_valid) & ~fifo_full;
        in0_ready  = fifo_wr_en & ~grant1;
        in1_ready  = fifo_wr_en & grant1;
        fifo_din   = grant1 ? in1_data : in0_data;
        rr_d       = fifo_wr_en ? ~grant1 : rr_q;
    end

    // Drain FSM: next state, counters and the start/pop pulses
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        sent_d     = sent_q;
        drop_d     = drop_q;
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_start   = 1'b0;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                tx_data_d  = fifo_dout;
                tx_start   = 1'b1;
                fifo_rd_en = 1'b1;
                to_cnt_d   = '0;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    sent_d  = sent_q + CNT_WIDTH'(1);
                    state_d = S_BUSY;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    if (to_cnt_d == TW'(ACK_TIMEOUT)) begin
                        drop_d  = drop_q + CNT_WIDTH'(1);
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_BUSY: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_d == GW'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            tx_data_q <= '0;
            sent_q    <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            tx_data_q <= tx_data_d;
            sent_q    <= sent_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign sent_count  = sent_q;
    assign drop_count  = drop_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: producers, FIFO and transmitter models around the
// scheduler, with a write/transmit scoreboard and timing checks.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int W     = 8;
    localparam int GAP   = 2;
    localparam int ACKT  = 16;
    localparam int CW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          in0_valid = 1'b0;
    logic [W-1:0]  in0_data  = '0;
    logic          in0_ready;
    logic          in1_valid = 1'b0;
    logic [W-1:0]  in1_data  = '0;
    logic          in1_ready;
    logic          fifo_wr_en;
    logic [W-1:0]  fifo_din;
    logic          fifo_full;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_dout  = '0;
    logic          fifo_empty = 1'b1;
    logic          tx_start;
    logic [W-1:0]  tx_data;
    logic          tx_busy = 1'b0;
    logic [CW-1:0] sent_count;
    logic [CW-1:0] drop_count;
    logic          timeout_err;

    uart_tx_scheduler #(
        .WIDTH(W), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .sent_count(sent_count), .drop_count(drop_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // bench state
    int           cyc = 0;
    logic [W-1:0] fq[$];
    int           fcnt = 0;
    logic         force_full = 1'b0;
    logic [W-1:0] src0[$];
    logic [W-1:0] src1[$];
    int           p0 = 100;
    int           p1 = 100;
    logic         rr_m = 1'b0;
    logic [W-1:0] exp_tx[$];
    logic [W-1:0] wr_log[$];
    int           wr_ch[$];
    int           wr_cyc = -1;
    int           starts[$];
    int           tx_ack = 1;
    int           tx_blen = 4;
    bit           tx_rand = 1'b0;
    int           drop_n = 0;
    int           exp_sent = 0;
    int           exp_drop = 0;

    assign fifo_full = force_full | (fcnt >= DEPTH);

    // FIFO model: flags and head register lag the queue by one edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            fq.delete();
            fcnt       <= 0;
            fifo_empty <= 1'b1;
            fifo_dout  <= '0;
        end else begin
            fifo_empty <= (fq.size() == 0);
            if (fq.size() > 0) fifo_dout <= fq[0];
            if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
            if (fifo_wr_en) fq.push_back(fifo_din);
            fcnt <= fq.size();
        end
    end

    // producers plus arbitration reference
    initial begin
        bit           acc0, acc1, v0, v1;
        int           g;
        logic [W-1:0] e;
        acc0 = 1'b0;
        acc1 = 1'b0;
        forever begin
            @(negedge clk);
            if (acc0 && src0.size() > 0) void'(src0.pop_front());
            if (acc1 && src1.size() > 0) void'(src1.pop_front());
            acc0 = 1'b0;
            acc1 = 1'b0;
            v0 = (src0.size() > 0) && ($urandom_range(99) < p0);
            v1 = (src1.size() > 0) && ($urandom_range(99) < p1);
            in0_valid = v0;
            in0_data  = v0 ? src0[0] : W'($urandom);
            in1_valid = v1;
            in1_data  = v1 ? src1[0] : W'($urandom);
            #1;
            if (rst) begin
                rr_m = 1'b0;
            end else begin
                g = -1;
                if (!fifo_full) begin
                    if (v0 && v1) g = rr_m ? 1 : 0;
                    else if (v0) g = 0;
                    else if (v1) g = 1;
                end
                chk("arb_grant", {fifo_wr_en, in1_ready, in0_ready},
                    {(g >= 0), (g == 1), (g == 0)});
                if (g >= 0) begin
                    e = (g == 1) ? src1[0] : src0[0];
                    chk("arb_din", fifo_din, e);
                    exp_tx.push_back(e);
                    wr_log.push_back(e);
                    wr_ch.push_back(g);
                    wr_cyc = cyc;
                    rr_m = (g == 0);
                    if (g == 0) acc0 = 1'b1;
                    else acc1 = 1'b1;
                end
            end
        end
    end

    // transmit monitor: pop expected byte when the DUT loads one
    initial begin
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (pend) begin
                pend = 1'b0;
                chk("tx_expected_avail", (exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) chk("tx_data", tx_data, exp_tx.pop_front());
            end
            if (tx_start || fifo_rd_en) chk("rd_en_with_start", fifo_rd_en, tx_start);
            if (!rst && tx_start) begin
                starts.push_back(cyc);
                pend = 1'b1;
            end
        end
    end

    // transmitter model: busy rises a cycles after start, lasts b cycles
    initial begin
        int a, b;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && tx_start) begin
                if (drop_n > 0) begin
                    drop_n--;
                    exp_drop++;
                end else begin
                    a = tx_rand ? int'($urandom_range(1, 4)) : tx_ack;
                    b = tx_rand ? int'($urandom_range(1, 6)) : tx_blen;
                    repeat (a) @(negedge clk);
                    tx_busy = 1'b1;
                    exp_sent++;
                    repeat (b) @(negedge clk);
                    tx_busy = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        src0.delete();
        src1.delete();
        exp_tx.delete();
        starts.delete();
        wr_log.delete();
        wr_ch.delete();
        exp_sent = 0;
        exp_drop = 0;
        drop_n   = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k;
        k = 0;
        while (starts.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("start_seen", (starts.size() >= n), 1);
    endtask

    task automatic wait_drain(input int budget);
        int q, k;
        bit ok;
        q = 0;
        k = 0;
        ok = 1'b0;
        while (!ok && k < budget) begin
            @(negedge clk);
            #2;
            k++;
            if (src0.size() == 0 && src1.size() == 0 && exp_tx.size() == 0 &&
                !tx_busy && fcnt == 0) q++;
            else q = 0;
            if (q >= 24) ok = 1'b1;
        end
        chk("drain_done", ok, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_before, en_cyc, nw;
        logic [W-1:0] e;

        // reset state
        do_reset();
        #2;
        chk("rst_sent", sent_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rd_en", fifo_rd_en, 0);

        // single byte latency
        en = 1'b1;
        tx_ack = 1;
        tx_blen = 10;
        src0.push_back(8'h55);
        wait_starts(1, 30);
        if (starts.size() > 0) chk("latency", starts[0] - (wr_cyc + 1), 3);
        @(negedge clk);
        #2;
        chk("tx_data_55", tx_data, 8'h55);
        wait_drain(200);
        chk("sent_single", sent_count, exp_sent);

        // interleaved producers, drain disabled
        do_reset();
        en = 1'b0;
        p0 = 100;
        p1 = 100;
        for (int i = 0; i < 4; i++) begin
            src0.push_back(8'hA0 + W'(i));
            src1.push_back(8'hB0 + W'(i));
        end
        repeat (12) @(negedge clk);
        chk("order_len", wr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
            e = (i % 2 == 1) ? 8'hB0 + W'(i / 2) : 8'hA0 + W'(i / 2);
            chk("write_order", wr_log[i], e);
        end
        en = 1'b1;
        tx_rand = 1'b1;
        wait_drain(400);
        chk("sent_interleave", sent_count, exp_sent);
        chk("drop_interleave", drop_count, exp_drop);

        // FIFO full holds off both producers
        en = 1'b0;
        tx_rand = 1'b0;
        @(negedge clk);
        force_full = 1'b1;
        wr_log.delete();
        wr_ch.delete();
        for (int i = 0; i < 3; i++) begin
            src0.push_back(8'h10 + W'(i));
            src1.push_back(8'h20 + W'(i));
        end
        repeat (5) @(negedge clk);
        nw = wr_log.size();
        chk("full_no_write", nw, 0);
        rr_before = int'(rr_m);
        force_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_full_writes", (wr_ch.size() > 0), 1);
        if (wr_ch.size() > 0) chk("post_full_grant", wr_ch[0], rr_before);
        en = 1'b1;
        wait_drain(400);

        // ack timeout, then the next byte goes normally
        starts.delete();
        tx_ack = 1;
        tx_blen = 3;
        drop_n = 1;
        src0.push_back(8'h3C);
        src1.push_back(8'hC3);
        wait_starts(2, 100);
        if (starts.size() > 1) chk("timeout_spacing", starts[1] - starts[0], ACKT + 3);
        chk("timeout_err_set", timeout_err, 1);
        chk("drop_after_timeout", drop_count, exp_drop);
        wait_drain(300);
        chk("timeout_err_sticky", timeout_err, 1);
        chk("sent_after_timeout", sent_count, exp_sent);
        chk("drop_total", drop_count, exp_drop);

        // byte period with a fixed transmitter
        en = 1'b0;
        tx_ack = 2;
        tx_blen = 5;
        src0.push_back(8'h11);
        src0.push_back(8'h22);
        src0.push_back(8'h33);
        repeat (6) @(negedge clk);
        starts.delete();
        en = 1'b1;
        wait_starts(3, 100);
        if (starts.size() > 2) begin
            chk("spacing_1", starts[1] - starts[0], 3 + 2 + 5 + GAP);
            chk("spacing_2", starts[2] - starts[1], 3 + 2 + 5 + GAP);
        end
        wait_drain(300);

        // en dropped while a byte is busy
        en = 1'b0;
        tx_ack = 1;
        tx_blen = 8;
        src1.push_back(8'h5A);
        src1.push_back(8'hA5);
        repeat (4) @(negedge clk);
        starts.delete();
        en = 1'b1;
        wait_starts(1, 30);
        nw = 0;
        while (!tx_busy && nw < 10) begin
            @(negedge clk);
            #2;
            nw++;
        end
        @(negedge clk);
        en = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_start_disabled", starts.size(), 1);
        en = 1'b1;
        en_cyc = cyc;
        wait_starts(2, 20);
        if (starts.size() > 1) chk("en_restart", starts[1] - en_cyc, 2);
        wait_drain(300);

        // reset while waiting for busy
        starts.delete();
        drop_n = 1;
        src0.push_back(8'h77);
        wait_starts(1, 30);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_sent", sent_count, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_err", timeout_err, 0);
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        src0.delete();
        src1.delete();
        exp_tx.delete();
        starts.delete();
        exp_sent = 0;
        exp_drop = 0;
        drop_n = 0;
        rst = 1'b0;

        // randomized traffic
        en = 1'b1;
        tx_rand = 1'b1;
        p0 = int'($urandom_range(30, 100));
        p1 = int'($urandom_range(30, 100));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 0) src0.push_back(W'($urandom));
            else src1.push_back(W'($urandom));
            force_full = ($urandom_range(9) == 0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            force_full = 1'b0;
        end
        wait_drain(3000);
        chk("rand_sent", sent_count, exp_sent);
        chk("rand_drop", drop_count, exp_drop);
        chk("rand_err", timeout_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
